// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - operand/result bundle between the execute stage and mul_sequencer
//
// Purpose : groups the request, flush and result/handshake signals of the
//           multi-cycle multiplier so they travel as one port.
// Signals : start_i    execute stage holds a valid instruction this cycle
//           ALUCtrl_i  ALU control code of that instruction
//           data1_i    multiplicand
//           data2_i    multiplier
//           flush_i    synchronous abort (pipeline flush)
//           result_o   low WIDTH bits of the product
//           valid_o    one-cycle pulse, result_o holds a new product
//           busy_o     operation in flight
//           stall_o    freeze the upstream pipeline registers
// Modports: master = execute stage side, slave = multiplier side.

interface mul_sequencer_if #(
   parameter int WIDTH = 32
);

   logic             start_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic             flush_i;
   logic [WIDTH-1:0] result_o;
   logic             valid_o;
   logic             busy_o;
   logic             stall_o;

   modport master (
      output start_i,
      output ALUCtrl_i,
      output data1_i,
      output data2_i,
      output flush_i,
      input  result_o,
      input  valid_o,
      input  busy_o,
      input  stall_o
   );

   modport slave (
      input  start_i,
      input  ALUCtrl_i,
      input  data1_i,
      input  data2_i,
      input  flush_i,
      output result_o,
      output valid_o,
      output busy_o,
      output stall_o
   );

endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-add multiplier with its own IDLE/RUN/DONE sequencer
//
// Purpose : serves the MUL ALU code in the execute stage. One operand pair is
//           accepted in IDLE, one multiplier bit is consumed per cycle in RUN,
//           and the product is presented for a single cycle in DONE, which is
//           also the only busy cycle in which the pipeline is released.
// Ports   : clk_i  clock, rising edge
//           rst_i  asynchronous active-low reset
//           bus    mul_sequencer_if.slave (start_i, ALUCtrl_i, data1_i,
//                  data2_i, flush_i in; result_o, valid_o, busy_o, stall_o out)
// Params  : WIDTH     operand/result width
//           MUL_CODE  ALUCtrl_i value that launches a multiply
// Options : MUL_SEQUENCER_EARLY_TERM_EN - leave RUN as soon as the remaining
//           multiplier bits are all zero instead of always iterating WIDTH times.

module mul_sequencer #(
   parameter int         WIDTH    = 32,
   parameter logic [2:0] MUL_CODE = 3'b011
) (
   input  logic           clk_i,
   input  logic           rst_i,
   mul_sequencer_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcnd_q;
   logic [WIDTH-1:0] mplr_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;

   logic             accept;
   logic [WIDTH-1:0] acc_step;
   logic [CW-1:0]    cnt_step;
   logic             last_iter;

   // A launch request is only honoured from IDLE; flush is handled by the
   // consumers of this term so that stall_o keeps its plain definition.
   assign accept   = (state_q == IDLE) && bus.start_i && (bus.ALUCtrl_i == MUL_CODE);

   assign acc_step = mplr_q[0] ? (acc_q + mcnd_q) : acc_q;
   assign cnt_step = cnt_q + CW'(1);

`ifdef MUL_SEQUENCER_EARLY_TERM_EN
   // Once the bits still to be shifted in are all zero, further iterations
   // cannot change the accumulator, so the result is already final.
   assign last_iter = (cnt_step == CNT_LAST) || (mplr_q[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt_step == CNT_LAST);
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!bus.flush_i && accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else if (last_iter) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: operand latch, shift-add iteration, completed-product hold
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q    <= '0;
         mcnd_q   <= '0;
         mplr_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && !bus.flush_i) begin
                  acc_q  <= '0;
                  mcnd_q <= bus.data1_i;
                  mplr_q <= bus.data2_i;
                  cnt_q  <= '0;
               end
            end
            RUN: begin
               if (!bus.flush_i) begin
                  acc_q  <= acc_step;
                  mcnd_q <= mcnd_q << 1;
                  mplr_q <= mplr_q >> 1;
                  cnt_q  <= cnt_step;
               end
            end
            DONE: begin
               // A product flushed in its DONE cycle never becomes the held value.
               if (!bus.flush_i) begin
                  result_q <= acc_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      bus.valid_o  = 1'b0;
      bus.result_o = result_q;
      bus.busy_o   = 1'b0;
      bus.stall_o  = 1'b0;
      case (state_q)
         IDLE: begin
            bus.stall_o = accept;
         end
         RUN: begin
            bus.busy_o  = 1'b1;
            bus.stall_o = 1'b1;
         end
         DONE: begin
            bus.busy_o = 1'b1;
            // Stall is dropped here so EX/MEM captures result_o at the next edge.
            if (!bus.flush_i) begin
               bus.valid_o  = 1'b1;
               bus.result_o = acc_q;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed self-checking bench for mul_sequencer

module tb_mul_sequencer;

`ifdef MUL_SEQUENCER_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [2:0] MUL = 3'b011;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mul_sequencer_if #(.WIDTH(32)) bus ();

   mul_sequencer #(.WIDTH(32), .MUL_CODE(MUL)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch a MUL, optionally re-pulse start_i with other operands after edge
   // E<poke>, and check latency, stall coverage and the result window.
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat_full, input int lat_early,
                          input int poke);
      int lat;
      int n;
      bit stall_ok;
      lat = EARLY ? lat_early : lat_full;
      @(negedge clk_i);
      bus.start_i   = 1'b1;
      bus.ALUCtrl_i = MUL;
      bus.data1_i   = a;
      bus.data2_i   = b;
      #1;
      check({tag, "_stall_accept"}, bus.stall_o, 1);
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      n = 0;
      stall_ok = 1'b1;
      while (!bus.valid_o && n < 200) begin
         if (!bus.stall_o || !bus.busy_o) stall_ok = 1'b0;
         if (n == poke) begin
            bus.start_i = 1'b1;
            bus.data1_i = 32'h0000_DEAD;
            bus.data2_i = 32'h0000_0077;
         end else begin
            bus.start_i = 1'b0;
         end
         @(posedge clk_i);
         #1;
         n++;
      end
      bus.start_i = 1'b0;
      check({tag, "_latency"}, n, lat);
      check({tag, "_stall_run"}, stall_ok, 1);
      check({tag, "_result_done"}, bus.result_o, exp);
      check({tag, "_stall_done"}, bus.stall_o, 0);
      check({tag, "_busy_done"}, bus.busy_o, 1);
      @(posedge clk_i);
      #1;
      check({tag, "_valid_after"}, bus.valid_o, 0);
      check({tag, "_busy_after"}, bus.busy_o, 0);
      check({tag, "_result_hold"}, bus.result_o, exp);
   endtask

   initial begin
      bit seen_valid;
      bus.start_i   = 1'b0;
      bus.ALUCtrl_i = 3'b000;
      bus.data1_i   = '0;
      bus.data2_i   = '0;
      bus.flush_i   = 1'b0;

      // Reset state
      #12;
      check("rst_result", bus.result_o, 0);
      check("rst_valid", bus.valid_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_stall", bus.stall_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Non-MUL code is not accepted
      @(negedge clk_i);
      bus.start_i   = 1'b1;
      bus.ALUCtrl_i = 3'b010;
      bus.data1_i   = 32'd4;
      bus.data2_i   = 32'd4;
      #1;
      check("nonmul_stall", bus.stall_o, 0);
      @(posedge clk_i);
      #1;
      check("nonmul_busy", bus.busy_o, 0);
      bus.start_i = 1'b0;

      run_mul("mul_7x6", 32'd7, 32'd6, 32'd42, 32, 3, -1);
      run_mul("wrap_ffff", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32, 2, -1);
      run_mul("wrap_10000", 32'h0001_0000, 32'h0001_0000, 32'd0, 32, 17, -1);
      run_mul("ignore_start", 32'd3, 32'd4, 32'd12, 32, 3, EARLY ? 1 : 5);
      run_mul("mul_9x9", 32'd9, 32'd9, 32'd81, 32, 4, -1);

      // Flush mid-operation: back to IDLE, no valid, previous product held
      @(negedge clk_i);
      bus.start_i   = 1'b1;
      bus.ALUCtrl_i = MUL;
      bus.data1_i   = 32'd5;
      bus.data2_i   = 32'h8000_0005;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      seen_valid = 1'b0;
      repeat (10) begin
         @(posedge clk_i);
         #1;
         if (bus.valid_o) seen_valid = 1'b1;
      end
      bus.flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.flush_i = 1'b0;
      check("flush_busy", bus.busy_o, 0);
      check("flush_stall", bus.stall_o, 0);
      check("flush_result", bus.result_o, 32'd81);
      repeat (40) begin
         @(posedge clk_i);
         #1;
         if (bus.valid_o) seen_valid = 1'b1;
      end
      check("flush_no_valid", seen_valid, 0);
      check("flush_result_later", bus.result_o, 32'd81);

      run_mul("mul_5x3", 32'd5, 32'd3, 32'd15, 32, 2, -1);
      run_mul("mul_9x0", 32'd9, 32'd0, 32'd0, 32, 1, -1);

      // Asynchronous reset mid-operation
      @(negedge clk_i);
      bus.start_i   = 1'b1;
      bus.ALUCtrl_i = MUL;
      bus.data1_i   = 32'd3;
      bus.data2_i   = 32'h8000_0003;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      check("arst_result", bus.result_o, 0);
      check("arst_valid", bus.valid_o, 0);
      check("arst_busy", bus.busy_o, 0);
      check("arst_stall", bus.stall_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      seen_valid = 1'b0;
      repeat (40) begin
         @(posedge clk_i);
         #1;
         if (bus.valid_o) seen_valid = 1'b1;
      end
      check("arst_no_valid", seen_valid, 0);

      run_mul("mul_1x80000000", 32'd1, 32'h8000_0000, 32'h8000_0000, 32, 32, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Multi-cycle shift-add multiplier with its own sequencing FSM. It serves ALU control code 3'b011 (MUL) in the CPU execute stage.
- Accepts one operand pair and iterates one multiplier bit per cycle.
- Holds the pipeline via stall_o while the operation runs.
- Releases the pipeline for the single cycle in which the product is presented on result_o.

Parameters:
WIDTH, 32, operand and result width in bits; iteration counter width is clog2(WIDTH)+1.
MUL_CODE, 3'b011, ALUCtrl_i value that launches a multiply.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-low reset.
start_i  input  1  execute stage holds a valid instruction this cycle.
ALUCtrl_i  input  3  ALU control code of that instruction.
data1_i  input  WIDTH  multiplicand.
data2_i  input  WIDTH  multiplier.
flush_i  input  1  synchronous abort (pipeline flush).
result_o  output  WIDTH  low WIDTH bits of the product.
valid_o  output  1  one-cycle pulse: result_o holds a new product.
busy_o  output  1  operation in flight (state != IDLE).
stall_o  output  1  freeze the upstream pipeline registers.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE; accumulator, multiplicand, multiplier and counter = 0.
  - result_o=0, valid_o=0, busy_o=0, stall_o=0.
  - Reset mid-operation aborts the operation; no valid_o is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when start_i=1 and ALUCtrl_i==MUL_CODE. On edge E0, latch data1_i into the multiplicand and data2_i into the multiplier, clear accumulator and counter, go to RUN.
  - Any other ALUCtrl_i: no action; stall_o=0.
- RUN, one iteration per edge:
  - If multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH).
  - Multiplicand <<= 1; multiplier >>= 1; counter += 1.
  - When the counter reaches WIDTH on this edge, go to DONE.
- DONE: result_o = accumulator; valid_o=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: accepted at E0, valid_o high between E(WIDTH) and E(WIDTH+1), i.e. WIDTH+1 cycles.
- Throughput: one multiply per WIDTH+2 cycles.
- stall_o is combinational:
  - stall_o = (IDLE & start_i & ALUCtrl_i==MUL_CODE) | RUN.
  - stall_o is 0 in DONE, so the EX/MEM register captures result_o at E(WIDTH+1).
- busy_o = 1 in RUN and DONE.
- start_i in RUN or DONE is ignored; operands are not re-sampled.
- Back-to-back MUL: after DONE the stalled-then-released instruction has moved on. A new MUL presented in IDLE is accepted normally.
- flush_i:
  - In RUN or DONE: go to IDLE at the next edge; no valid_o; result_o keeps its previous value. In DONE, the flush also suppresses valid_o in that cycle.
  - In IDLE: flush_i has priority over start_i; nothing is accepted.
- Simultaneous rst_i and flush_i: reset wins.
- result_o holds the last completed product until the next DONE. It is unsigned low-half, which is identical for signed operands.

Optional Feature:
Macro MUL_SEQUENCER_EARLY_TERM_EN.
- Defined: in RUN, if the shifted multiplier (multiplier>>1) is zero after the current iteration, go to DONE on that edge regardless of the counter. Minimum RUN length is 1 cycle, so minimum latency is 2 cycles with data2_i=0 or 1.
- Undefined: fixed WIDTH iterations; latency is always WIDTH+1.
- Results are identical in both builds.

Test Plan:
- Reset, then idle: result_o=0, valid_o=0, busy_o=0, stall_o=0; start_i=1 with ALUCtrl_i=3'b010 -> stall_o stays 0, no accept.
- WIDTH=32, 7*6, feature off: stall_o high from the accept cycle through E32; valid_o=1 only between E32 and E33 with result_o=42; stall_o=0 in that cycle; busy_o=0 after E33.
- 0xFFFFFFFF*2 -> result_o=0xFFFFFFFE (wrap); 0x10000*0x10000 -> result_o=0.
- start_i pulsed again at E5 with new operands during 3*4 -> ignored; result 12 at E32; next MUL 9*9 in IDLE -> 81.
- flush_i at E10 of 5*5 -> IDLE at E11, no valid_o, result_o keeps the prior value; rst_i low at E20 of another op -> all outputs 0 asynchronously.
- Feature on: 5*3 -> valid_o between E2 and E3, result_o=15; 9*0 -> valid_o between E1 and E2, result_o=0; 1*0x80000000 -> full 32 iterations, result_o=0x80000000.
